// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : core/loader request buses plus memory pins
// Revision: 1.0
// ============================================================================

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ack;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_lock;
  logic              l_ack;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_we;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output l_req, l_we, l_addr, l_wdata, l_lock,
    input  c_ack, l_ack, rdata, busy,
    input  mem_address, mem_data_in, mem_we,
    output mem_data_out
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  l_req, l_we, l_addr, l_wdata, l_lock,
    output c_ack, l_ack, rdata, busy,
    output mem_address, mem_data_in, mem_we,
    input  mem_data_out
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : round-robin arbiter sharing one memory port (core/loader)
// Revision: 1.0
// ============================================================================

module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ACCESS = 2'd1;
  localparam logic [1:0] c_ST_DONE   = 2'd2;

  localparam logic c_OWN_CORE = 1'b0;
  localparam logic c_OWN_LDR  = 1'b1;

  localparam int                 c_CNT_W    = $clog2(MAX_LOCK + 1);
  localparam logic [c_CNT_W-1:0] c_LOCK_MAX = c_CNT_W'(MAX_LOCK);

  logic [1:0]         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               c_ack_q, c_ack_d;
  logic               l_ack_q, l_ack_d;
  logic [c_CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  logic w_any_req;
  logic w_grant_core;
  logic w_b2b;

  assign w_any_req    = bus.c_req | bus.l_req;
  // On a tie the port that did not own the memory last time wins.
  assign w_grant_core = bus.c_req & (~bus.l_req | (last_owner_q == c_OWN_LDR));
  assign w_b2b        = (state_q == c_ST_DONE) && (owner_q == c_OWN_LDR) &&
                        bus.l_lock && bus.l_req && (lock_cnt_q < c_LOCK_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= c_ST_IDLE;
      owner_q      <= c_OWN_CORE;
      last_owner_q <= c_OWN_LDR;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      c_ack_q      <= 1'b0;
      l_ack_q      <= 1'b0;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      c_ack_q      <= c_ack_d;
      l_ack_q      <= l_ack_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:   if (w_any_req) state_d = c_ST_ACCESS;
      c_ST_ACCESS: state_d = c_ST_DONE;
      c_ST_DONE:   state_d = w_b2b ? c_ST_ACCESS : c_ST_IDLE;
      default:     state_d = c_ST_IDLE;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    lock_cnt_d   = lock_cnt_q;
    c_ack_d      = 1'b0;
    l_ack_d      = 1'b0;

    case (state_q)
      c_ST_IDLE: begin
        if (w_any_req) begin
          if (w_grant_core) begin
            owner_d    = c_OWN_CORE;
            we_d       = bus.c_we;
            addr_d     = bus.c_addr;
            wdata_d    = bus.c_wdata;
            lock_cnt_d = '0;
          end else begin
            owner_d    = c_OWN_LDR;
            we_d       = bus.l_we;
            addr_d     = bus.l_addr;
            wdata_d    = bus.l_wdata;
          end
        end
      end
      c_ST_ACCESS: begin
        if (!we_q) rdata_d = bus.mem_data_out;
        c_ack_d      = (owner_q == c_OWN_CORE);
        l_ack_d      = (owner_q == c_OWN_LDR);
        last_owner_d = owner_q;
      end
      c_ST_DONE: begin
        if (w_b2b) begin
          owner_d = c_OWN_LDR;
          we_d    = bus.l_we;
          addr_d  = bus.l_addr;
          wdata_d = bus.l_wdata;
        end
        // The lock budget only drains while the core is actually waiting.
        if (!bus.c_req)  lock_cnt_d = '0;
        else if (w_b2b)  lock_cnt_d = lock_cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.mem_address = '0;
    bus.mem_data_in = '0;
    bus.mem_we      = 1'b0;
    if (state_q == c_ST_ACCESS) begin
      bus.mem_address = addr_q;
      bus.mem_data_in = wdata_q;
      bus.mem_we      = we_q;
    end
    bus.busy  = (state_q == c_ST_ACCESS) || (state_q == c_ST_DONE);
    bus.c_ack = c_ack_q;
    bus.l_ack = l_ack_q;
    bus.rdata = rdata_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed checks of the core/loader memory arbiter
// Revision: 1.0
// ============================================================================

module tb_mem_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_LOCK = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Small behavioural memory; bench preloads share its single write process.
  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (bus.mem_we)  mem[bus.mem_address[7:0]] <= bus.mem_data_in;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign bus.mem_data_out = mem[bus.mem_address[7:0]];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] exp_rd [0:3];
  int cyc0;
  int n;

  initial begin
    reset       = 1'b0;
    pre_we      = 1'b0;
    pre_addr    = '0;
    pre_data    = '0;
    bus.c_req   = 1'b0;
    bus.c_we    = 1'b0;
    bus.c_addr  = '0;
    bus.c_wdata = '0;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_addr  = '0;
    bus.l_wdata = '0;
    bus.l_lock  = 1'b0;
    exp_rd[0] = 32'hC0DE0030;
    exp_rd[1] = 32'hC0DE0030;
    exp_rd[2] = 32'hC0DE0031;
    exp_rd[3] = 32'hC0DE0031;

    // Reset state
    tick();
    tick();
    check("rst_cack", bus.c_ack, 0);
    check("rst_lack", bus.l_ack, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_address, 0);
    check("rst_din", bus.mem_data_in, 0);
    reset = 1'b1;
    tick();

    preload(8'h10, 32'hDEADBEEF);
    preload(8'h30, 32'hC0DE0030);
    preload(8'h31, 32'hC0DE0031);

    // Core read alone
    bus.c_req  = 1'b1;
    bus.c_we   = 1'b0;
    bus.c_addr = 32'h10;
    tick();
    check("rd_addr", bus.mem_address, 32'h10);
    check("rd_we", bus.mem_we, 0);
    check("rd_busy", bus.busy, 1);
    check("rd_cack_early", bus.c_ack, 0);
    tick();
    check("rd_cack", bus.c_ack, 1);
    check("rd_data", bus.rdata, 32'hDEADBEEF);
    check("rd_lack", bus.l_ack, 0);
    check("rd_memaddr_done", bus.mem_address, 0);
    bus.c_req = 1'b0;
    tick();
    check("rd_cack_pulse", bus.c_ack, 0);
    check("rd_busy_idle", bus.busy, 0);
    check("rd_data_hold", bus.rdata, 32'hDEADBEEF);

    // Loader write, then read back through the core
    check("wr_we_idle", bus.mem_we, 0);
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_addr  = 32'h20;
    bus.l_wdata = 32'h12345678;
    tick();
    check("wr_we", bus.mem_we, 1);
    check("wr_addr", bus.mem_address, 32'h20);
    check("wr_din", bus.mem_data_in, 32'h12345678);
    check("wr_lack_early", bus.l_ack, 0);
    tick();
    check("wr_we_done", bus.mem_we, 0);
    check("wr_lack", bus.l_ack, 1);
    check("wr_cack", bus.c_ack, 0);
    check("wr_rdata_kept", bus.rdata, 32'hDEADBEEF);
    bus.l_req = 1'b0;
    bus.l_we  = 1'b0;
    tick();
    check("wr_we_after", bus.mem_we, 0);
    bus.c_req  = 1'b1;
    bus.c_addr = 32'h20;
    tick();
    tick();
    check("wrrb_cack", bus.c_ack, 1);
    check("wrrb_data", bus.rdata, 32'h12345678);
    bus.c_req = 1'b0;
    tick();

    // Tie after reset: core, loader, core, loader
    do_reset();
    cyc0        = cycle;
    bus.c_req   = 1'b1;
    bus.c_we    = 1'b0;
    bus.c_addr  = 32'h30;
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_addr  = 32'h60;
    bus.l_wdata = 32'h600D0000;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!(bus.c_ack || bus.l_ack) && n < 8);
      check("tie_cycle", 64'(cycle - cyc0), 64'(2 + 3 * k));
      check("tie_cack", bus.c_ack, (k % 2) == 0);
      check("tie_lack", bus.l_ack, (k % 2) == 1);
      check("tie_rdata", bus.rdata, exp_rd[k]);
      if ((k % 2) == 0) bus.c_addr = 32'h31;
      else              bus.l_addr = 32'h61;
    end
    bus.c_req = 1'b0;
    bus.l_req = 1'b0;
    tick();
    check("tie_memwr", mem[8'h60], 32'h600D0000);

    // Locked loader burst, core waiting from cycle 1, MAX_LOCK = 4
    do_reset();
    cyc0        = cycle;
    bus.l_req   = 1'b1;
    bus.l_lock  = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_addr  = 32'h70;
    bus.l_wdata = 32'hAAAA5555;
    tick();
    bus.c_req  = 1'b1;
    bus.c_we   = 1'b0;
    bus.c_addr = 32'h20;
    check("lk_busy", bus.busy, 1);
    for (int i = 2; i <= 13; i++) begin
      tick();
      check($sformatf("lk_lack@%0d", i), bus.l_ack, (i <= 10) && ((i % 2) == 0));
      check($sformatf("lk_cack@%0d", i), bus.c_ack, i == 13);
    end
    check("lk_rdata", bus.rdata, 32'h12345678);
    bus.c_req  = 1'b0;
    bus.l_req  = 1'b0;
    bus.l_lock = 1'b0;
    bus.l_we   = 1'b0;
    tick();
    tick();

    // Reset asserted in the middle of a write access
    bus.c_req   = 1'b1;
    bus.c_we    = 1'b1;
    bus.c_addr  = 32'h50;
    bus.c_wdata = 32'h55;
    tick();
    check("ra_we_access", bus.mem_we, 1);
    #2;
    reset = 1'b0;
    #1;
    check("ra_we_async", bus.mem_we, 0);
    check("ra_addr_async", bus.mem_address, 0);
    check("ra_din_async", bus.mem_data_in, 0);
    check("ra_busy_async", bus.busy, 0);
    tick();
    check("ra_cack", bus.c_ack, 0);
    check("ra_lack", bus.l_ack, 0);
    check("ra_rdata", bus.rdata, 0);
    reset = 1'b1;
    tick();
    check("ra_re_we", bus.mem_we, 1);
    check("ra_re_addr", bus.mem_address, 32'h50);
    tick();
    check("ra_re_cack", bus.c_ack, 1);
    check("ra_re_rdata", bus.rdata, 0);
    bus.c_req = 1'b0;
    bus.c_we  = 1'b0;
    tick();
    check("ra_mem", mem[8'h50], 32'h55);

    // Idle quiet for 20 cycles
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_ctl", {bus.busy, bus.mem_we, bus.c_ack, bus.l_ack}, 0);
      check("idle_addr", bus.mem_address, 0);
      check("idle_rdata", bus.rdata, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
